// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, 16x8 RAM, IR, A, B and adder/subtractor sharing one
// bus. It executes the controller's 12-bit control word on every rising edge.
// A sticky halt flag freezes every register until reset. The RAM can be
// loaded through the program port while the machine is in reset or halted.
module sap1_datapath #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       ctrl,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] a_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              carry,
  output logic              halted,
  output logic              bus_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Control word fields.
  logic hlt, pc_inc, pc_en, mem_load, mem_en, ir_load, ir_en;
  logic a_load, a_en, b_load, adder_sub, adder_en;

  assign hlt       = ctrl[11];
  assign pc_inc    = ctrl[10];
  assign pc_en     = ctrl[9];
  assign mem_load  = ctrl[8];
  assign mem_en    = ctrl[7];
  assign ir_load   = ctrl[6];
  assign ir_en     = ctrl[5];
  assign a_load    = ctrl[4];
  assign a_en      = ctrl[3];
  assign b_load    = ctrl[2];
  assign adder_sub = ctrl[1];
  assign adder_en  = ctrl[0];

  // Architectural state.
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              carry_q, carry_d;
  logic              halted_q, halted_d;
  logic [DATA_W-1:0] ram_q [DEPTH];

  // Adder/subtractor: subtraction is a + ~b + 1, so the carry-out means "no borrow".
  logic [DATA_W:0]   add_full;
  logic [DATA_W-1:0] add_b;
  logic [DATA_W-1:0] sum;
  logic              add_c;

  // Form the adder operand and the extended-width sum.
  always_comb begin
    add_b    = adder_sub ? ~b_q : b_q;
    add_full = {1'b0, a_q} + {1'b0, add_b} + {{DATA_W{1'b0}}, adder_sub};
    sum      = add_full[DATA_W-1:0];
    add_c    = add_full[DATA_W];
  end

  // Drive the bus from the highest-priority enabled source and flag multiple drivers.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    bus          = '0;
    bus_conflict = 1'b0;
    if (pc_en)         bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
    else if (mem_en)   bus = ram_q[mar_q];
    else if (ir_en)    bus = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
    else if (a_en)     bus = a_q;
    else if (adder_en) bus = sum;
    bus_conflict = (3'(pc_en) + 3'(mem_en) + 3'(ir_en) + 3'(a_en) + 3'(adder_en)) > 3'd1;
  end

  // Compute next register state; nothing moves once halted.
  always_comb begin
    pc_d     = pc_q;
    mar_d    = mar_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (pc_inc)   pc_d  = pc_q + 1'b1;
      if (mem_load) mar_d = bus[ADDR_W-1:0];
      if (ir_load)  ir_d  = bus;
      if (a_load)   a_d   = bus;
      if (b_load)   b_d   = bus;
      if (a_load && adder_en) carry_d = add_c;
      if (hlt)      halted_d = 1'b1;
    end
  end

  // Register update with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= '0;
      mar_q    <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge bus.
      pc_q     <= pc_d;
      mar_q    <= mar_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      halted_q <= halted_d;
    end
  end

  // Program-load port: writes are accepted only while in reset or halted.
  // NOTE: the RAM has no reset so a loaded program survives a reset pulse.
  always_ff @(posedge clk) begin
    if (prog_we && (rst || halted_q)) ram_q[prog_addr] <= prog_data;
  end

  assign opcode = ir_q[DATA_W-1:DATA_W-4];
  assign a_out  = a_q;
  assign pc_out = pc_q;
  assign carry  = carry_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_sap1_datapath.sv
// Testbench for sap1_datapath. A small controller model drives control words.
// Expected values are queued when a word is applied and compared after the edge.
module tb_sap1_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [11:0] ctrl = '0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [3:0] opcode;
  logic [7:0] bus;
  logic [7:0] a_out;
  logic [3:0] pc_out;
  logic       carry;
  logic       halted;
  logic       bus_conflict;

  sap1_datapath #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl         (ctrl),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .opcode       (opcode),
    .bus          (bus),
    .a_out        (a_out),
    .pc_out       (pc_out),
    .carry        (carry),
    .halted       (halted),
    .bus_conflict (bus_conflict)
  );

  always #5 clk = ~clk;

  typedef enum {S_A, S_PC, S_CARRY, S_HALT, S_OPC, S_BUS, S_CONF} sig_e;
  typedef struct {
    string    tag;
    sig_e     sig;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input sig_e sig, input logic [7:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Pop every pending expectation and compare it against the live outputs.
  task automatic drain();
    exp_t e;
    logic [7:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sig)
        S_A:     obs = a_out;
        S_PC:    obs = {4'h0, pc_out};
        S_CARRY: obs = {7'h0, carry};
        S_HALT:  obs = {7'h0, halted};
        S_OPC:   obs = {4'h0, opcode};
        S_BUS:   obs = bus;
        default: obs = {7'h0, bus_conflict};
      endcase
      check(e.tag, obs, e.exp);
    end
  endtask

  // Apply one control word for one rising edge, then check results.
  task automatic step(input logic [11:0] w);
    ctrl = w;
    @(posedge clk);
    #1;
    drain();
  endtask

  // Apply a control word and check combinational outputs without an edge.
  task automatic peek(input logic [11:0] w);
    ctrl = w;
    #1;
    drain();
  endtask

  task automatic prog_write(input logic [3:0] addr, input logic [7:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    step(12'h000);
    prog_we   = 1'b0;
  endtask

  // Controller model: fetch then execute the instruction held in IR.
  task automatic run_instr(input bit chk, input logic [7:0] exp_a, input logic exp_c);
    step(12'h300);
    step(12'h400);
    step(12'h0C0);
    case (opcode)
      4'h0: begin
        step(12'h120);
        if (chk) begin
          expect_val("lda_a", S_A, exp_a);
          expect_val("lda_c", S_CARRY, {7'h0, exp_c});
        end
        step(12'h090);
      end
      4'h1, 4'h2: begin
        step(12'h120);
        step(12'h084);
        if (chk) begin
          expect_val("alu_a", S_A, exp_a);
          expect_val("alu_c", S_CARRY, {7'h0, exp_c});
        end
        step((opcode == 4'h2) ? 12'h013 : 12'h011);
      end
      default: step(12'h800);
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and arithmetic program load.
    expect_val("rst_a", S_A, 8'h00);
    expect_val("rst_pc", S_PC, 8'h00);
    expect_val("rst_halt", S_HALT, 8'h00);
    expect_val("rst_carry", S_CARRY, 8'h00);
    expect_val("rst_opc", S_OPC, 8'h00);
    expect_val("rst_bus", S_BUS, 8'h00);
    step(12'h000);
    prog_write(4'd0,  8'h09);  // LDA 9
    prog_write(4'd1,  8'h2A);  // SUB 10
    prog_write(4'd2,  8'h0A);  // LDA 10
    prog_write(4'd3,  8'h29);  // SUB 9
    prog_write(4'd4,  8'h0B);  // LDA 11
    prog_write(4'd5,  8'h1C);  // ADD 12
    prog_write(4'd6,  8'h0D);  // LDA 13
    prog_write(4'd7,  8'h1E);  // ADD 14
    prog_write(4'd8,  8'h0F);  // LDA 15
    prog_write(4'd9,  8'h07);
    prog_write(4'd10, 8'h05);
    prog_write(4'd11, 8'h10);
    prog_write(4'd12, 8'h20);
    prog_write(4'd13, 8'hFF);
    prog_write(4'd14, 8'h02);
    prog_write(4'd15, 8'h3C);
    rst = 1'b0;

    // A program write while running must be ignored.
    prog_write(4'd13, 8'h55);

    run_instr(1'b1, 8'h07, 1'b0);
    run_instr(1'b1, 8'h02, 1'b1);  // 7 - 5
    run_instr(1'b1, 8'h05, 1'b1);  // carry held
    run_instr(1'b1, 8'hFE, 1'b0);  // 5 - 7 borrows
    run_instr(1'b1, 8'h10, 1'b0);
    run_instr(1'b1, 8'h30, 1'b0);  // 0x10 + 0x20
    run_instr(1'b1, 8'hFF, 1'b0);  // RAM unchanged by running write
    run_instr(1'b1, 8'h01, 1'b1);  // 0xFF + 0x02 overflow
    run_instr(1'b1, 8'h3C, 1'b1);

    // Walk pc 9 -> 6 through the 15 -> 0 wrap, then halt with increment.
    for (int i = 0; i < 13; i++) begin
      if (i == 12) expect_val("pc_wrap_inc", S_PC, 8'h06);
      step(12'h400);
    end
    expect_val("hlt_halt", S_HALT, 8'h01);
    expect_val("hlt_pc", S_PC, 8'h07);
    step(12'hC00);
    expect_val("frz_pc", S_PC, 8'h07);
    step(12'h400);
    expect_val("frz_a", S_A, 8'h3C);
    expect_val("frz_c", S_CARRY, 8'h01);
    step(12'h011);

    // Asynchronous reset pulse in the middle of a cycle.
    #2;
    rst = 1'b1;
    expect_val("arst_a", S_A, 8'h00);
    expect_val("arst_pc", S_PC, 8'h00);
    expect_val("arst_halt", S_HALT, 8'h00);
    expect_val("arst_carry", S_CARRY, 8'h00);
    peek(12'h000);
    expect_val("arst_ram", S_BUS, 8'h09);
    expect_val("arst_noconf", S_CONF, 8'h00);
    peek(12'h080);

    // System program: LDA 14, ADD 15, SUB 13, HLT.
    prog_write(4'd0,  8'h0E);
    prog_write(4'd1,  8'h1F);
    prog_write(4'd2,  8'h2D);
    prog_write(4'd3,  8'hF0);
    prog_write(4'd13, 8'h02);
    prog_write(4'd14, 8'h05);
    prog_write(4'd15, 8'h03);
    rst = 1'b0;

    expect_val("f1_bus_pc", S_BUS, 8'h00);
    peek(12'h300);
    expect_val("f1_pc", S_PC, 8'h00);
    step(12'h300);
    expect_val("f2_pc", S_PC, 8'h01);
    step(12'h400);
    expect_val("f3_opc", S_OPC, 8'h00);
    step(12'h0C0);
    expect_val("f3_ir_lo", S_BUS, 8'h0E);
    peek(12'h020);
    step(12'h120);
    expect_val("mar_e_ram", S_BUS, 8'h05);
    peek(12'h080);
    expect_val("lda14_a", S_A, 8'h05);
    step(12'h090);
    run_instr(1'b1, 8'h08, 1'b0);
    run_instr(1'b1, 8'h06, 1'b1);
    run_instr(1'b0, 8'h00, 1'b0);
    expect_val("sys_a", S_A, 8'h06);
    expect_val("sys_halt", S_HALT, 8'h01);
    expect_val("sys_pc", S_PC, 8'h04);
    step(12'h000);

    // Program write accepted while halted; MAR still points at address 3.
    prog_write(4'd3, 8'hAA);
    expect_val("halt_load", S_BUS, 8'hAA);
    peek(12'h080);

    // Bus conflict with pc wrap.
    rst = 1'b1;
    step(12'h000);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 14) expect_val("pc_15", S_PC, 8'h0F);
      step(12'h400);
    end
    expect_val("conf_bus", S_BUS, 8'h0F);
    expect_val("conf_flag", S_CONF, 8'h01);
    peek(12'h608);
    expect_val("conf_wrap", S_PC, 8'h00);
    step(12'h608);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sap1_datapath.md
Name: sap1_datapath

Overview:
Datapath consumed directly downstream of the SAP-1 controller. It takes the 12-bit control word each cycle and executes it on an 8-bit shared bus. The bus connects the PC, MAR, 16x8 RAM, IR, A, B and the adder/subtractor. It returns the IR opcode nibble to the controller. It also provides a program-load port for writing RAM while the machine is in reset or halted.

Parameters:
ADDR_W, 4, address width of PC, MAR and RAM index; RAM depth is 2**ADDR_W.
DATA_W, 8, width of the bus, RAM words, IR, A, B and the adder; opcode is IR[DATA_W-1:DATA_W-4].

Ports:
clk  input  1  clock; all datapath registers update on the rising edge (the controller advances on the falling edge).
rst  input  1  reset, asynchronous, active-high.
ctrl  input  12  control word: [11]HLT [10]PC_INC [9]PC_EN [8]MEM_LOAD(MAR load) [7]MEM_EN(RAM drive) [6]IR_LOAD [5]IR_EN [4]A_LOAD [3]A_EN [2]B_LOAD [1]ADDER_SUB [0]ADDER_EN.
prog_we  input  1  RAM program write strobe.
prog_addr  input  ADDR_W  RAM program write address.
prog_data  input  DATA_W  RAM program write data.
opcode  output  4  IR[7:4], fed to the controller.
bus  output  DATA_W  current bus value (combinational).
a_out  output  DATA_W  accumulator A.
pc_out  output  ADDR_W  program counter.
carry  output  1  carry/no-borrow flag from the last adder write-back.
halted  output  1  sticky halt flag.
bus_conflict  output  1  high when more than one bus driver is enabled (combinational).

Behaviour:
- Bus sources, with fixed priority PC_EN > MEM_EN > IR_EN > A_EN > ADDER_EN:
  - PC_EN drives zero-extended pc.
  - MEM_EN drives ram[mar].
  - IR_EN drives zero-extended ir[3:0].
  - A_EN drives a.
  - ADDER_EN drives sum.
- If no driver is enabled, bus = 0.
- bus_conflict = 1 whenever two or more of the driver-enable bits are set; the bus value still follows the priority order.
- Adder (combinational):
  - ADDER_SUB=0: {c,sum} = a + b.
  - ADDER_SUB=1: {c,sum} = a + ~b + 1.
  - Result is DATA_W bits and wraps modulo 2**DATA_W.
  - c is the carry out of bit DATA_W-1; on subtract, c=1 means no borrow.
- Rising-edge updates, applied only while halted=0 (all applied in the same edge from the pre-edge bus value):
  - PC_INC: pc <= pc+1, wrapping 15 -> 0.
  - MEM_LOAD: mar <= bus[ADDR_W-1:0].
  - IR_LOAD: ir <= bus.
  - A_LOAD: a <= bus.
  - B_LOAD: b <= bus.
  - A_LOAD with ADDER_EN: carry <= c. Carry is otherwise held.
- Simultaneous PC_INC and PC_EN: the bus carries the old pc and pc increments.
- HLT: when ctrl[11]=1 at a rising edge with halted=0:
  - halted <= 1 on that edge.
  - The other bits of that same word still take effect.
  - From the next edge onward, all registers freeze until rst.
- Program writes: on a rising edge, ram[prog_addr] <= prog_data when prog_we=1 and (rst=1 or halted=1). prog_we is ignored while running.
- Reset (asynchronous, any time including mid-instruction):
  - pc, mar, ir, a, b, carry and halted clear to 0 immediately.
  - Consequently opcode=0, a_out=0, pc_out=0, and bus=0 unless ctrl enables a driver.
  - RAM contents are not cleared.
- No RAM read latency: ram[mar] is a combinational read.
- RAM contents before any program write are undefined; the bench preloads them.

Test Plan:
- Reset: pulse rst mid-run with a=0x3C, pc=7, halted=1 -> a_out=0, pc_out=0, halted=0, carry=0 asynchronously; a RAM word written earlier still reads back.
- Fetch: ram[0]=0x0E, pc=0; apply ctrl 0x300, then 0x400, then 0x0C0, one rising edge each -> mar=0, pc_out=1, opcode=0x0, ir=0x0E; then ctrl 0x120 -> mar=0xE.
- Add overflow: a=0xFF, b=0x02; ctrl 0x011 -> a_out=0x01, carry=1. Then a=0x10, b=0x20 -> a_out=0x30, carry=0.
- Subtract: a=0x07, b=0x05; ctrl 0x013 -> a_out=0x02, carry=1. Then a=0x05, b=0x07 -> a_out=0xFE, carry=0.
- Halt and load: ctrl 0xC00 -> halted=1, pc increments once; subsequent 0x400 and 0x011 words change nothing; prog_we addr 3 data 0xAA accepted. Also check that prog_we while running leaves RAM unchanged.
- Conflict and wrap: pc=15; ctrl 0x608 -> bus=0x0F, bus_conflict=1, pc_out wraps to 0.
- System co-sim with the controller:
  - RAM: 0=0x0E, 1=0x1F, 2=0x2D, 3=0xF0, 13=0x02, 14=0x05, 15=0x03.
  - Required: a_out=0x06, halted=1, pc_out=4.
